bc_moment_reader: RTL and testbench
===================================

Name: bc_moment_reader

Overview:
- Reads back a box-count grid that the square-grid coarsening stage has written into the BC memory.
- Scans the grid in raster order through a 1-cycle-latency synchronous RAM port.
- Accumulates the partition-function terms for multifractal analysis: sum of counts (q=1), sum of squares (q=2) and the number of occupied boxes.
- Sits between the BC memory read port and the MFA controller, which launches one scan per box level via a start/done handshake.

Parameters:
- BOX_IDX, 3, log2 of full grid side; grid side = 2**BOX_IDX.
- DATA_LEN, 8, width of one box-count word.
- ACC_LEN, 24, width of sum and sum_sq accumulators; must be >= 2*DATA_LEN.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous active-high reset.
- start  input  1  one-cycle launch pulse; sampled only in IDLE.
- bank  input  1  BC memory half to read; driven onto address bit BOX_IDX.
- half  input  1  1 = scan the (2**(BOX_IDX-1))^2 subgrid (x,y MSB forced 0); 0 = full grid. Sampled with start.
- rd_data  input  DATA_LEN  RAM data, valid the cycle after rd_addr.
- rd_addr  output  2*BOX_IDX+1  {x[BOX_IDX-1:0], bank, y[BOX_IDX-1:0]}.
- rd_en  output  1  high while an address is issued.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when results are final.
- sum  output  ACC_LEN  sum of all read words.
- sum_sq  output  ACC_LEN  sum of squares of all read words.
- nz_cnt  output  2*BOX_IDX+1  number of nonzero words.
- ovf  output  1  sticky: sum or sum_sq saturated during the current scan.

Behaviour:
- Synchronous reset: all outputs 0; state IDLE; bank/half latches 0.
- States:
  - IDLE: start=1 latches bank and half, clears sum/sum_sq/nz_cnt/ovf and the x,y counters, then goes to READ.
  - READ: issues one address per cycle with rd_en=1. x increments fastest, 0..S-1, with S=2**BOX_IDX, or S/2 when half=1. At x wrap, x returns to 0 and y increments. After issuing (x,y)=(S-1,S-1), goes to DRAIN.
  - DRAIN: rd_en=0; accumulates the last word; goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0; returns to IDLE.
- Data path:
  - A valid flag delayed one cycle from rd_en qualifies rd_data.
  - When valid: sum += rd_data, sum_sq += rd_data*rd_data (full 2*DATA_LEN-bit product, zero-extended), nz_cnt += (rd_data != 0).
- Saturation:
  - Each accumulator clamps at all-ones on unsigned overflow and stays there for the rest of the scan.
  - ovf is set on the first clamp and cleared only by the next accepted start or by reset.
- Timing: start accepted at cycle 0; addresses issued in cycles 1..N (N = S*S); last data accumulated in cycle N+1; done=1 in cycle N+2. Results are valid from the done cycle and held until the next accepted start.
- busy: 1 in READ and DRAIN, 0 otherwise.
- start while busy or in DONE is ignored; no queuing.
- RST mid-scan: returns to IDLE the next edge, clears everything, and produces no done pulse.
- rd_addr holds its last value when rd_en=0.

Optional Feature:
- Macro BC_MAX_TRACK_EN.
- When defined: extra output max_val [DATA_LEN-1:0], cleared on start and updated to the largest valid rd_data of the scan; it is final at done.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- All words 1, half=0, bank=1, BOX_IDX=3 -> sum=64, sum_sq=64, nz_cnt=64, ovf=0, done exactly at cycle 66 after start; first rd_addr = {3'd0,1'b1,3'd0}, second = {3'd1,1'b1,3'd0}.
- Word(x,y)=x+y, half=1 -> only x,y in 0..3 addressed; sum=48, sum_sq=184, nz_cnt=15, done at cycle 18.
- All words 255, ACC_LEN=16, half=0 -> sum=16320, sum_sq=65535 (saturated), ovf=1.
- Second start pulse during READ -> ignored; results and done timing identical to a single-start run.
- RST asserted at cycle 10 of a scan -> outputs 0 next cycle, no done pulse; a new start then completes normally with correct sums.
- BC_MAX_TRACK_EN defined, a single word 200 among zeros -> max_val=200, nz_cnt=1, sum=200, sum_sq=40000.

Source files
------------

// File: rtl/bc_moment_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : bc_moment_reader_if
// Description : Bundles the scan control handshake, the BC memory read port
//               and the moment results of bc_moment_reader.
//               slave  - the reader itself: takes start/bank/half/rd_data,
//                        drives rd_addr/rd_en, busy/done and the results.
//               master - the surrounding environment (MFA controller plus
//                        BC memory port).
//               Optional macro: BC_MAX_TRACK_EN adds max_val.
// Revision    : 1.0 - initial release
// ============================================================================
interface bc_moment_reader_if #(
    parameter int BOX_IDX  = 3,
    parameter int DATA_LEN = 8,
    parameter int ACC_LEN  = 24
);
    localparam int c_ADDR_LEN = 2 * BOX_IDX + 1;

    logic                  start;
    logic                  bank;
    logic                  half;
    logic [DATA_LEN-1:0]   rd_data;
    logic [c_ADDR_LEN-1:0] rd_addr;
    logic                  rd_en;
    logic                  busy;
    logic                  done;
    logic [ACC_LEN-1:0]    sum;
    logic [ACC_LEN-1:0]    sum_sq;
    logic [c_ADDR_LEN-1:0] nz_cnt;
    logic                  ovf;
`ifdef BC_MAX_TRACK_EN
    logic [DATA_LEN-1:0]   max_val;

    modport slave (
        input  start, bank, half, rd_data,
        output rd_addr, rd_en, busy, done, sum, sum_sq, nz_cnt, ovf, max_val
    );
    modport master (
        output start, bank, half, rd_data,
        input  rd_addr, rd_en, busy, done, sum, sum_sq, nz_cnt, ovf, max_val
    );
`else
    modport slave (
        input  start, bank, half, rd_data,
        output rd_addr, rd_en, busy, done, sum, sum_sq, nz_cnt, ovf
    );
    modport master (
        output start, bank, half, rd_data,
        input  rd_addr, rd_en, busy, done, sum, sum_sq, nz_cnt, ovf
    );
`endif
endinterface
`default_nettype wire

// File: rtl/bc_moment_reader.sv
`default_nettype none
// ============================================================================
// Module      : bc_moment_reader
// Description : Raster-scans a box-count grid from the BC memory (1-cycle
//               synchronous read) and accumulates sum, sum of squares and
//               the count of nonzero boxes, with saturating accumulators and
//               a sticky overflow flag. One scan per start/done handshake.
// Ports       : CLK, RST (sync, active high)
//               bus.start/bank/half   - scan launch and configuration
//               bus.rd_addr/rd_en     - memory address {x, bank, y}, enable
//               bus.rd_data           - memory data, one cycle after address
//               bus.busy/done         - scan status
//               bus.sum/sum_sq/nz_cnt - results, valid from done
//               bus.ovf               - an accumulator saturated this scan
//               bus.max_val           - largest word (BC_MAX_TRACK_EN only)
// Options     : BC_MAX_TRACK_EN - enables max_val tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module bc_moment_reader #(
    parameter int BOX_IDX  = 3,
    parameter int DATA_LEN = 8,
    parameter int ACC_LEN  = 24
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    bc_moment_reader_if.slave bus
);
    localparam int c_ADDR_LEN = 2 * BOX_IDX + 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [BOX_IDX-1:0] c_FULL_MAX = '1;
    localparam logic [BOX_IDX-1:0] c_HALF_MAX = c_FULL_MAX >> 1;

    logic [1:0]            r_state;
    logic                  r_bank;
    logic                  r_half;
    logic [BOX_IDX-1:0]    r_x;
    logic [BOX_IDX-1:0]    r_y;
    logic                  r_valid;
    logic [ACC_LEN-1:0]    r_sum;
    logic [ACC_LEN-1:0]    r_sum_sq;
    logic [c_ADDR_LEN-1:0] r_nz;
    logic                  r_ovf;

    logic [BOX_IDX-1:0]    w_last;
    logic                  w_rd_en;
    logic [2*DATA_LEN-1:0] w_sq;
    logic [ACC_LEN:0]      w_sum_ext;
    logic [ACC_LEN:0]      w_sum_sq_ext;
    logic                  w_nz_inc;

    assign w_last  = r_half ? c_HALF_MAX : c_FULL_MAX;
    assign w_rd_en = (r_state == c_ST_READ);

    // Accumulate one bit wider than the register so the carry flags overflow.
    assign w_sq         = {{DATA_LEN{1'b0}}, bus.rd_data} * {{DATA_LEN{1'b0}}, bus.rd_data};
    assign w_sum_ext    = {1'b0, r_sum} + {{(ACC_LEN+1-DATA_LEN){1'b0}}, bus.rd_data};
    assign w_sum_sq_ext = {1'b0, r_sum_sq} + {{(ACC_LEN+1-2*DATA_LEN){1'b0}}, w_sq};
    assign w_nz_inc     = (bus.rd_data != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_ST_IDLE;
            r_bank   <= 1'b0;
            r_half   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_valid  <= 1'b0;
            r_sum    <= '0;
            r_sum_sq <= '0;
            r_nz     <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= w_rd_en;

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_bank  <= bus.bank;
                        r_half  <= bus.half;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_state <= c_ST_READ;
                    end
                end
                c_ST_READ: begin
                    // Counters freeze on the final address so rd_addr holds.
                    if (r_x == w_last) begin
                        if (r_y == w_last) begin
                            r_state <= c_ST_DRAIN;
                        end else begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                        end
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                c_ST_DRAIN: r_state <= c_ST_DONE;
                default:    r_state <= c_ST_IDLE;
            endcase

            if ((r_state == c_ST_IDLE) && bus.start) begin
                r_sum    <= '0;
                r_sum_sq <= '0;
                r_nz     <= '0;
                r_ovf    <= 1'b0;
            end else if (r_valid) begin
                // A clamped accumulator stays all-ones: any further nonzero
                // addend overflows again and zero leaves it unchanged.
                if (w_sum_ext[ACC_LEN]) begin
                    r_sum <= '1;
                    r_ovf <= 1'b1;
                end else begin
                    r_sum <= w_sum_ext[ACC_LEN-1:0];
                end
                if (w_sum_sq_ext[ACC_LEN]) begin
                    r_sum_sq <= '1;
                    r_ovf    <= 1'b1;
                end else begin
                    r_sum_sq <= w_sum_sq_ext[ACC_LEN-1:0];
                end
                r_nz <= r_nz + {{(c_ADDR_LEN-1){1'b0}}, w_nz_inc};
            end
        end
    end

`ifdef BC_MAX_TRACK_EN
    logic [DATA_LEN-1:0] r_max;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_max <= '0;
        end else if ((r_state == c_ST_IDLE) && bus.start) begin
            r_max <= '0;
        end else if (r_valid && (bus.rd_data > r_max)) begin
            r_max <= bus.rd_data;
        end
    end

    assign bus.max_val = r_max;
`endif

    assign bus.rd_addr = {r_x, r_bank, r_y};
    assign bus.rd_en   = w_rd_en;
    assign bus.busy    = (r_state == c_ST_READ) || (r_state == c_ST_DRAIN);
    assign bus.done    = (r_state == c_ST_DONE);
    assign bus.sum     = r_sum;
    assign bus.sum_sq  = r_sum_sq;
    assign bus.nz_cnt  = r_nz;
    assign bus.ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bc_moment_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bc_moment_reader
// Description : Directed scoreboard bench for bc_moment_reader (BOX_IDX=3,
//               DATA_LEN=8, ACC_LEN=16). Scans push their hand-computed
//               results; a monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bc_moment_reader;
    localparam int c_BOX = 3;
    localparam int c_DL  = 8;
    localparam int c_AL  = 16;

    typedef struct {
        logic [c_AL-1:0] sum;
        logic [c_AL-1:0] sum_sq;
        logic [6:0]      nz;
        logic            ovf;
        logic [c_DL-1:0] maxv;
        int              done_cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    logic [c_DL-1:0] mem [0:127];

    bc_moment_reader_if #(.BOX_IDX(c_BOX), .DATA_LEN(c_DL), .ACC_LEN(c_AL)) bus ();

    bc_moment_reader #(.BOX_IDX(c_BOX), .DATA_LEN(c_DL), .ACC_LEN(c_AL)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // BC memory model: synchronous read, one cycle latency.
    always @(posedge CLK) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] addr(input int x, input int b, input int y);
        logic [31:0] xv, yv, bv;
        xv = x; yv = y; bv = b;
        return {xv[2:0], bv[0], yv[2:0]};
    endfunction

    function automatic exp_t mk(input int s, input int sq, input int nz, input int o, input int mx);
        exp_t e;
        e.sum = s[c_AL-1:0]; e.sum_sq = sq[c_AL-1:0]; e.nz = nz[6:0];
        e.ovf = o[0]; e.maxv = mx[c_DL-1:0]; e.done_cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && bus.done) begin
            if (q.size() == 0) begin
                check("spurious_done", {31'd0, bus.done}, 32'd0);
            end else begin
                e = q.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("sum",    {16'd0, bus.sum},    {16'd0, e.sum});
                check("sum_sq", {16'd0, bus.sum_sq}, {16'd0, e.sum_sq});
                check("nz_cnt", {25'd0, bus.nz_cnt}, {25'd0, e.nz});
                check("ovf",    {31'd0, bus.ovf},    {31'd0, e.ovf});
                check("busy_at_done", {31'd0, bus.busy}, 32'd0);
`ifdef BC_MAX_TRACK_EN
                check("max_val", {24'd0, bus.max_val}, {24'd0, e.maxv});
`endif
            end
        end
    end

    // Launch a scan; optionally check the first two addresses and inject a
    // second start (with inverted config) at cycle extra_at while busy.
    task automatic run_scan(input logic b, input logic h, input int n, input exp_t e,
                            input bit chk_addr, input int extra_at);
        int j;
        @(negedge CLK);
        bus.start = 1'b1; bus.bank = b; bus.half = h;
        e.done_cyc = cyc + n + 2;
        q.push_back(e);
        @(negedge CLK);
        bus.start = 1'b0; bus.bank = 1'b0; bus.half = 1'b0;
        j = 1;
        while (j < 200 && q.size() != 0) begin
            if (chk_addr && j == 1) begin
                check("rd_en_c1", {31'd0, bus.rd_en}, 32'd1);
                check("addr0", {25'd0, bus.rd_addr}, {25'd0, addr(0, b, 0)});
            end
            if (chk_addr && j == 2)
                check("addr1", {25'd0, bus.rd_addr}, {25'd0, addr(1, b, 0)});
            if (j == extra_at) begin
                bus.start = 1'b1; bus.bank = ~b; bus.half = ~h;
            end
            if (j == extra_at + 1) begin
                bus.start = 1'b0; bus.bank = 1'b0; bus.half = 1'b0;
            end
            @(negedge CLK);
            j++;
        end
        if (q.size() != 0) begin
            check("scan_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic fill(input int mode);
        for (int x = 0; x < 8; x++)
            for (int b = 0; b < 2; b++)
                for (int y = 0; y < 8; y++)
                    case (mode)
                        0: mem[addr(x, b, y)] = (b == 1) ? 8'd1 : 8'd0;
                        1: mem[addr(x, b, y)] = 8'(x + y);
                        2: mem[addr(x, b, y)] = 8'd255;
                        default: mem[addr(x, b, y)] = 8'd0;
                    endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.bank = 1'b0; bus.half = 1'b0;
        fill(3);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_busy",  {31'd0, bus.busy},  32'd0);
        check("rst_done",  {31'd0, bus.done},  32'd0);
        check("rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
        check("rst_addr",  {25'd0, bus.rd_addr}, 32'd0);
        check("rst_sum",   {16'd0, bus.sum},   32'd0);
        check("rst_ovf",   {31'd0, bus.ovf},   32'd0);

        // All ones in bank 1, zeros in bank 0.
        fill(0);
        run_scan(1'b1, 1'b0, 64, mk(64, 64, 64, 0, 1), 1'b1, -10);

        // x+y, half grid.
        fill(1);
        run_scan(1'b0, 1'b1, 16, mk(48, 184, 15, 0, 6), 1'b1, -10);

        // Second start mid-scan with inverted bank/half must be ignored.
        fill(0);
        run_scan(1'b1, 1'b0, 64, mk(64, 64, 64, 0, 1), 1'b0, 5);

        // All 255: sum_sq saturates in a 16-bit accumulator.
        fill(2);
        run_scan(1'b0, 1'b0, 64, mk(16320, 65535, 64, 1, 255), 1'b0, -10);

        // Reset at cycle 10 of a scan: ovf is already set, then everything clears.
        @(negedge CLK);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (9) @(negedge CLK);
        check("ovf_pre_rst", {31'd0, bus.ovf}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mrst_busy",   {31'd0, bus.busy},   32'd0);
        check("mrst_done",   {31'd0, bus.done},   32'd0);
        check("mrst_rd_en",  {31'd0, bus.rd_en},  32'd0);
        check("mrst_addr",   {25'd0, bus.rd_addr}, 32'd0);
        check("mrst_sum",    {16'd0, bus.sum},    32'd0);
        check("mrst_sum_sq", {16'd0, bus.sum_sq}, 32'd0);
        check("mrst_nz",     {25'd0, bus.nz_cnt}, 32'd0);
        check("mrst_ovf",    {31'd0, bus.ovf},    32'd0);
        repeat (80) @(negedge CLK);

        fill(1);
        run_scan(1'b0, 1'b1, 16, mk(48, 184, 15, 0, 6), 1'b0, -10);

        // Single 200 among zeros.
        fill(3);
        mem[addr(5, 0, 6)] = 8'd200;
        run_scan(1'b0, 1'b0, 64, mk(200, 40000, 1, 0, 200), 1'b0, -10);

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
